// File: rtl/match_scoreboard.sv
// match_scoreboard: running tally of rock-paper-scissors round results.
// Counts P1 wins, P2 wins, ties and invalid rounds. It declares a match
// winner when a player reaches WIN_TARGET, or when MAX_ROUNDS counted rounds
// have been played.
// Optional streak tracking is enabled by defining MATCH_SCOREBOARD_STREAK_EN.
module match_scoreboard #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int ROUND_W    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_match,
    input  logic               round_valid,
    input  logic [1:0]         round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] tie_count,
    output logic [SCORE_W-1:0] invalid_count,
    output logic [ROUND_W-1:0] round_count,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic [1:0]         sb_state
`ifdef MATCH_SCOREBOARD_STREAK_EN
    ,
    output logic [SCORE_W-1:0] streak_len,
    output logic [1:0]         streak_owner
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_TARGET);
    localparam logic [ROUND_W-1:0] MAX_S  = ROUND_W'(MAX_ROUNDS);
    localparam logic [SCORE_W-1:0] SAT_S  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ZERO_S = {SCORE_W{1'b0}};
    localparam logic [ROUND_W-1:0] ZERO_R = {ROUND_W{1'b0}};

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == SAT_S) begin
            sat_inc = v;
        end else begin
            sat_inc = v + SCORE_W'(1);
        end
    endfunction

    // Winner when the round limit ends the match: higher score, or draw.
    function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] a,
                                             input logic [SCORE_W-1:0] b);
        if (a > b) begin
            winner_of = 2'b01;
        end else if (b > a) begin
            winner_of = 2'b10;
        end else begin
            winner_of = 2'b00;
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [SCORE_W-1:0] p1_r, p1_nxt_s, p2_r, p2_nxt_s;
    logic [SCORE_W-1:0] tie_r, tie_nxt_s, inv_r, inv_nxt_s;
    logic [ROUND_W-1:0] rnd_r, rnd_nxt_s;
    logic [1:0]         win_r, win_nxt_s;
    logic               over_r;
    logic [SCORE_W-1:0] slen_r, slen_nxt_s;
    logic [1:0]         sown_r, sown_nxt_s;

    // Next-state and tally update; the end-of-match check uses post-update counts.
    always_comb begin
        state_nxt_s = state_r;
        p1_nxt_s    = p1_r;
        p2_nxt_s    = p2_r;
        tie_nxt_s   = tie_r;
        inv_nxt_s   = inv_r;
        rnd_nxt_s   = rnd_r;
        win_nxt_s   = win_r;
        slen_nxt_s  = slen_r;
        sown_nxt_s  = sown_r;
        if (new_match) begin
            state_nxt_s = ST_PLAY;
            p1_nxt_s    = ZERO_S;
            p2_nxt_s    = ZERO_S;
            tie_nxt_s   = ZERO_S;
            inv_nxt_s   = ZERO_S;
            rnd_nxt_s   = ZERO_R;
            win_nxt_s   = 2'b00;
            slen_nxt_s  = ZERO_S;
            sown_nxt_s  = 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_PLAY: begin
                    if (round_valid) begin
                        case (round_result)
                            2'b00: begin
                                tie_nxt_s  = tie_r + SCORE_W'(1);
                                rnd_nxt_s  = rnd_r + ROUND_W'(1);
                                slen_nxt_s = ZERO_S;
                                sown_nxt_s = 2'b00;
                            end
                            2'b01: begin
                                p1_nxt_s  = p1_r + SCORE_W'(1);
                                rnd_nxt_s = rnd_r + ROUND_W'(1);
                                if (sown_r == 2'b01) begin
                                    slen_nxt_s = sat_inc(slen_r);
                                end else begin
                                    slen_nxt_s = SCORE_W'(1);
                                end
                                sown_nxt_s = 2'b01;
                            end
                            2'b10: begin
                                p2_nxt_s  = p2_r + SCORE_W'(1);
                                rnd_nxt_s = rnd_r + ROUND_W'(1);
                                if (sown_r == 2'b10) begin
                                    slen_nxt_s = sat_inc(slen_r);
                                end else begin
                                    slen_nxt_s = SCORE_W'(1);
                                end
                                sown_nxt_s = 2'b10;
                            end
                            default: inv_nxt_s = sat_inc(inv_r);
                        endcase
                        if (p1_nxt_s == WIN_S) begin
                            state_nxt_s = ST_DONE;
                            win_nxt_s   = 2'b01;
                        end else if (p2_nxt_s == WIN_S) begin
                            state_nxt_s = ST_DONE;
                            win_nxt_s   = 2'b10;
                        end else if (rnd_nxt_s == MAX_S) begin
                            state_nxt_s = ST_DONE;
                            win_nxt_s   = winner_of(p1_nxt_s, p2_nxt_s);
                        end else begin
                            state_nxt_s = ST_PLAY;
                        end
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                default: begin
                    // Corrupted state: return to a clean idle tally.
                    state_nxt_s = ST_IDLE;
                    p1_nxt_s    = ZERO_S;
                    p2_nxt_s    = ZERO_S;
                    tie_nxt_s   = ZERO_S;
                    inv_nxt_s   = ZERO_S;
                    rnd_nxt_s   = ZERO_R;
                    win_nxt_s   = 2'b00;
                    slen_nxt_s  = ZERO_S;
                    sown_nxt_s  = 2'b00;
                end
            endcase
        end
    end

    // State and tally registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            p1_r    <= ZERO_S;
            p2_r    <= ZERO_S;
            tie_r   <= ZERO_S;
            inv_r   <= ZERO_S;
            rnd_r   <= ZERO_R;
            win_r   <= 2'b00;
            over_r  <= 1'b0;
            slen_r  <= ZERO_S;
            sown_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            p1_r    <= p1_nxt_s;
            p2_r    <= p2_nxt_s;
            tie_r   <= tie_nxt_s;
            inv_r   <= inv_nxt_s;
            rnd_r   <= rnd_nxt_s;
            win_r   <= win_nxt_s;
            over_r  <= (state_nxt_s == ST_DONE);
            slen_r  <= slen_nxt_s;
            sown_r  <= sown_nxt_s;
        end
    end

    assign p1_score      = p1_r;
    assign p2_score      = p2_r;
    assign tie_count     = tie_r;
    assign invalid_count = inv_r;
    assign round_count   = rnd_r;
    assign match_over    = over_r;
    assign match_winner  = win_r;
    assign sb_state      = state_r;

`ifdef MATCH_SCOREBOARD_STREAK_EN
    assign streak_len    = slen_r;
    assign streak_owner  = sown_r;
`else
    // Streak registers are unused in this build.
    logic unused_streak_s;
    assign unused_streak_s = ^{slen_r, sown_r};
`endif

endmodule

// File: doc/match_scoreboard.md
Name: match_scoreboard

Overview:
Consumes the per-round `winner` code produced by the rock-paper-scissors round evaluator, one result per round, and keeps a running match tally. It tracks P1 wins, P2 wins, ties and invalid rounds, and declares a match winner when a player reaches a target score or a round limit is hit. It sits directly downstream of the round evaluator and feeds the display/UI logic.

Parameters:
- WIN_TARGET, 3, wins needed to take the match (1..2^SCORE_W-1)
- MAX_ROUNDS, 9, counted rounds (ties + wins) after which the match ends regardless of score
- SCORE_W, 4, width of the score, tie and invalid counters
- ROUND_W, 5, width of round_count; must hold MAX_ROUNDS

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- new_match  in  1  single-cycle pulse; clears the tally and starts a match
- round_valid  in  1  single-cycle pulse; round_result is valid this cycle
- round_result  in  2  00 tie, 01 P1 wins, 10 P2 wins, 11 invalid
- p1_score  out  SCORE_W  P1 round wins
- p2_score  out  SCORE_W  P2 round wins
- tie_count  out  SCORE_W  tied rounds
- invalid_count  out  SCORE_W  invalid rounds
- round_count  out  ROUND_W  counted rounds (ties + wins; invalid rounds excluded)
- match_over  out  1  high in DONE
- match_winner  out  2  00 draw/none, 01 P1, 10 P2; valid only while match_over=1
- sb_state  out  2  FSM state: 00 IDLE, 01 PLAY, 10 DONE

Behaviour:
- All outputs are registered. On reset_n=0, all counters are 0, match_over=0, match_winner=00 and sb_state=IDLE.
- IDLE: round_valid is ignored. new_match -> PLAY.
- PLAY, when round_valid=1 (takes effect next edge):
  - 00: tie_count+1, round_count+1
  - 01: p1_score+1, round_count+1
  - 10: p2_score+1, round_count+1
  - 11: invalid_count+1 only; round_count is unchanged
- Match end checks use the post-update values and are evaluated in the same cycle as the update. The counters, match_over, match_winner and sb_state=DONE all change on the same edge, one cycle after the deciding round_valid.
  - new p1_score == WIN_TARGET -> DONE, winner 01
  - new p2_score == WIN_TARGET -> DONE, winner 10
  - otherwise, if new round_count == MAX_ROUNDS -> DONE; winner is the player with the higher score, or 00 if the scores are equal
- DONE: counters and winner are held, and round_valid is ignored. new_match -> PLAY with everything cleared.
- new_match in any state clears all counters and the winner and sets the state to PLAY on the next edge.
- new_match and round_valid in the same cycle: new_match wins and the round is discarded (counters become 0).
- Saturation: invalid_count saturates at 2^SCORE_W-1 and does not wrap. Other counters cannot overflow given the parameter constraints.
- Illegal sb_state encoding 11 -> IDLE on the next edge.
- reset_n asserted mid-match clears everything immediately (asynchronous). The first edge after release stays in IDLE unless new_match is high.

Optional Feature:
MATCH_SCOREBOARD_STREAK_EN
- Defined:
  - adds output `streak_len` [SCORE_W-1:0], the current consecutive-win count of the last round winner
  - adds output `streak_owner` [1:0] (00 none, 01 P1, 10 P2)
  - a win by the same owner increments streak_len (saturating); a win by the other player sets owner to that player and streak_len=1
  - a tie resets owner to 00 and streak_len to 0
  - invalid rounds leave the streak unchanged
  - streak outputs are cleared by reset and new_match, and frozen in DONE
- Undefined: these ports do not exist, and the core behaviour is identical.

Test Plan:
- Reset then new_match; 01,01,01 with round_valid pulses -> after the 3rd round: p1_score=3, round_count=3, match_over=1, match_winner=01, sb_state=10.
- new_match; results 10,00,11,10,01,10 -> p2_score=3, p1_score=1, tie_count=1, invalid_count=1, round_count=5, match_winner=10.
- new_match; 9 alternating rounds with 2 wins each + 5 ties (MAX_ROUNDS=9) -> DONE at round_count=9, match_winner=00. Variant with P1 2, P2 1, ties 6 -> winner 01.
- In DONE, pulse round_valid=1 with 01 -> no counter change. Then new_match and round_valid(01) in the same cycle -> all counters 0, sb_state=01.
- reset_n low mid-match (p1_score=2) -> all outputs 0 and IDLE immediately. After release, round_valid with 01 and no new_match -> ignored.
- With STREAK_EN: 01,01,10,00 -> streak (01,1), (01,2), (10,1), (00,0).
